// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit count that indexes 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder used by the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first addition through one full-adder cell and a carry flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                    sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= cell_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode the state register only, so no input-to-output path exists.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=2 with a result scoreboard.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
    logic [1:0] a2, b2, sum2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] sb8[$];
    logic [2:0] sb2[$];
    int n_acc8 = 0, n_out8 = 0, spur8 = 0;
    int n_acc2 = 0, n_out2 = 0, spur2 = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: push on accept, pop on result handshake, flush on reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_acc8 -= sb8.size();
            sb8.delete();
        end else begin
            if (in_valid8 && in_ready8) begin
                sb8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
                n_acc8++;
            end
            if (out_valid8 && out_ready8) begin
                n_out8++;
                if (sb8.size() == 0) spur8++;
                else check("sb8_result", {cout8, sum8}, sb8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            n_acc2 -= sb2.size();
            sb2.delete();
        end else begin
            if (in_valid2 && in_ready2) begin
                sb2.push_back({1'b0, a2} + {1'b0, b2} + 3'(cin2));
                n_acc2++;
            end
            if (out_valid2 && out_ready2) begin
                n_out2++;
                if (sb2.size() == 0) spur2++;
                else check("sb2_result", {cout2, sum2}, sb2.pop_front());
            end
        end
    end

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready8) break;
        end
        check("accept_timeout", in_ready8, 1'b1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_done8();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid8) break;
        end
        check("result_timeout", out_valid8, 1'b1);
    endtask

    task automatic release8();
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    initial begin
        int pt[3];
        int npulse;
        int idx;
        int sent;
        int guard;
        logic acc;
        logic pending;
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        logic       tc[3];

        rst_n = 1'b0;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
        in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; out_ready2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready8, 1'b1);
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        check("rst_in_ready_w2", in_ready2, 1'b1);
        check("rst_out_valid_w2", out_valid2, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1: reset in the middle of a run discards the operation.
        a8 = 8'hA5; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("t1_running", in_ready8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1_rst_in_ready", in_ready8, 1'b1);
        check("t1_rst_out_valid", out_valid8, 1'b0);
        check("t1_rst_sum", sum8, 8'h00);
        check("t1_rst_cout", cout8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_hold_out_valid", out_valid8, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 2: zero add accepted on the first edge after reset; exact latency.
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("t2_latency_edge%0d", i), out_valid8, (i == 8));
        end
        check("t2_sum", sum8, 8'h00);
        check("t2_cout", cout8, 1'b0);
        release8();
        check("t2_back_idle", in_ready8, 1'b1);
        check("t2_no_valid", out_valid8, 1'b0);

        // Test 3: full carry ripple.
        send8(8'hFF, 8'h01, 1'b0);
        wait_done8();
        check("t3a_sum", sum8, 8'h00);
        check("t3a_cout", cout8, 1'b1);
        release8();
        send8(8'hFF, 8'hFF, 1'b1);
        wait_done8();
        check("t3b_sum", sum8, 8'hFF);
        check("t3b_cout", cout8, 1'b1);
        release8();

        // Test 4: backpressure in DONE with new operands waiting.
        send8(8'h12, 8'h34, 1'b0);
        wait_done8();
        @(posedge clk); #1;
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_sum", sum8, 8'h46);
            check("t4_hold_cout", cout8, 1'b0);
            check("t4_hold_in_ready", in_ready8, 1'b0);
            check("t4_hold_out_valid", out_valid8, 1'b1);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("t4_no_same_cycle_accept", in_ready8, 1'b1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("t4_accepted_next", in_ready8, 1'b0);
        wait_done8();
        check("t4_sum", sum8, 8'h97);
        check("t4_cout", cout8, 1'b0);
        release8();

        // Test 5: back-to-back with valid and ready held high.
        ta = '{8'h01, 8'h80, 8'h7F};
        tb = '{8'h02, 8'h80, 8'h01};
        tc = '{1'b0, 1'b1, 1'b1};
        idx = 0; npulse = 0;
        a8 = ta[0]; b8 = tb[0]; cin8 = tc[0];
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int c = 0; c < 60 && npulse < 3; c++) begin
            @(negedge clk);
            if (out_valid8) begin
                pt[npulse] = cyc;
                npulse++;
            end
            acc = in_valid8 && in_ready8;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    a8 = ta[idx]; b8 = tb[idx]; cin8 = tc[idx];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
        end
        out_ready8 = 1'b0;
        check("t5_pulses", npulse, 3);
        check("t5_spacing1", pt[1] - pt[0], 10);
        check("t5_spacing2", pt[2] - pt[1], 10);

        // Test 6a: random traffic at WIDTH=8.
        sent = 0; pending = 1'b0; guard = 0;
        while ((sent < 1000 || sb8.size() != 0) && guard < 40000) begin
            @(negedge clk);
            acc = in_valid8 && in_ready8;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                sent++; pending = 1'b0; in_valid8 = 1'b0;
            end
            if (!pending && sent < 1000 && $urandom_range(0, 2) != 0) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                in_valid8 = 1'b1; pending = 1'b1;
            end
            out_ready8 = ($urandom_range(0, 3) != 0);
        end
        out_ready8 = 1'b0; in_valid8 = 1'b0;
        check("t6_w8_done_in_time", guard < 40000, 1'b1);

        // Test 6b: random traffic at WIDTH=2.
        sent = 0; pending = 1'b0; guard = 0;
        while ((sent < 1000 || sb2.size() != 0) && guard < 40000) begin
            @(negedge clk);
            acc = in_valid2 && in_ready2;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                sent++; pending = 1'b0; in_valid2 = 1'b0;
            end
            if (!pending && sent < 1000 && $urandom_range(0, 2) != 0) begin
                a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
                in_valid2 = 1'b1; pending = 1'b1;
            end
            out_ready2 = ($urandom_range(0, 3) != 0);
        end
        out_ready2 = 1'b0; in_valid2 = 1'b0;
        check("t6_w2_done_in_time", guard < 40000, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb8_drained", sb8.size(), 0);
        check("sb8_no_spurious", spur8, 0);
        check("sb8_out_eq_acc", n_out8, n_acc8);
        check("sb2_drained", sb2.size(), 0);
        check("sb2_no_spurious", spur2, 0);
        check("sb2_out_eq_acc", n_out2, n_acc2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
